// File: rtl/bfly_pkg.sv
// Shared constants, beat/exponent types and the saturating arithmetic shift
// used by the stage-1 butterfly input path.
package bfly_pkg;

  localparam int NCHAN      = 16;
  localparam int W          = 11;
  localparam int EXP_W      = 5;
  localparam int HALF_BEATS = 16;
  localparam int CNT_W      = $clog2(2 * HALF_BEATS);
  localparam int ADDR_W     = $clog2(HALF_BEATS);

  typedef logic [EXP_W-1:0]          exp_t;
  typedef logic [NCHAN-1:0][W-1:0]   lanes_t;

  typedef struct packed {
    lanes_t re;
    lanes_t im;
  } cplx_beat_t;

  // Arithmetic right shift; shifts of W or more collapse to pure sign fill.
  function automatic logic [W-1:0] asr_sat(input logic [W-1:0] x, input exp_t d);
    if (int'(d) >= W) return {W{x[W-1]}};
    return W'($signed(x) >>> d);
  endfunction

endpackage

// File: rtl/bfly_half_buffer.sv
// Half-frame store: HALF_BEATS entries of one complex beat plus its exponent.
// Single address port shared by write and the combinational read.
module bfly_half_buffer
  import bfly_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  cplx_beat_t        wdata_i,
  input  exp_t              wexp_i,
  output cplx_beat_t        rdata_o,
  output exp_t              rexp_o
);

  // No reset: contents are meaningless until the first half-frame lands.
  cplx_beat_t mem_q [HALF_BEATS];
  exp_t       exp_q [HALF_BEATS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      exp_q[addr_i] <= wexp_i;
    end
  end

  assign rdata_o = mem_q[addr_i];
  assign rexp_o  = exp_q[addr_i];

endmodule

// File: rtl/bfly1_pair_buffer.sv
// Buffers the first half of each 32-beat frame and emits (x[n], x[n+256])
// butterfly pairs while the second half streams in. Define BFLY1_EXP_ALIGN_EN
// to align each pair to the smaller of its two block exponents.
module bfly1_pair_buffer
  import bfly_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  logic   valid_in,
  input  lanes_t data_re_in,
  input  lanes_t data_im_in,
  input  exp_t   exp_in,
  output logic   valid_out,
  output logic   frame_start,
  output lanes_t a_re,
  output lanes_t a_im,
  output lanes_t b_re,
  output lanes_t b_im,
  output exp_t   exp_a,
  output exp_t   exp_b
);

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             pair_phase, fire, first_pair;
  cplx_beat_t       wr_beat, rd_beat;
  exp_t             rd_exp;

  lanes_t a_re_d, a_im_d, b_re_d, b_im_d;
  exp_t   exp_a_d, exp_b_d;

  lanes_t a_re_q, a_im_q, b_re_q, b_im_q;
  exp_t   exp_a_q, exp_b_q;
  logic   valid_q, frame_start_q;

  assign pair_phase = beat_cnt_q[CNT_W-1];
  assign fire       = valid_in && pair_phase;
  assign first_pair = beat_cnt_q == CNT_W'(HALF_BEATS);
  assign beat_cnt_d = valid_in ? beat_cnt_q + 1'b1 : beat_cnt_q;
  assign wr_beat    = '{re: data_re_in, im: data_im_in};

  // Read and write share one address; the phases never overlap.
  bfly_half_buffer u_buf (
    .clk     (clk),
    .we_i    (valid_in && !pair_phase),
    .addr_i  (beat_cnt_q[ADDR_W-1:0]),
    .wdata_i (wr_beat),
    .wexp_i  (exp_in),
    .rdata_o (rd_beat),
    .rexp_o  (rd_exp)
  );

`ifdef BFLY1_EXP_ALIGN_EN
  logic a_gt;
  exp_t d;
  assign a_gt    = rd_exp > exp_in;
  assign d       = a_gt ? rd_exp - exp_in : exp_in - rd_exp;
  assign exp_a_d = a_gt ? exp_in : rd_exp;
  assign exp_b_d = exp_a_d;

  // Only the operand with the larger exponent is shifted down.
  for (genvar l = 0; l < NCHAN; l++) begin : g_align
    assign a_re_d[l] = a_gt ? asr_sat(rd_beat.re[l], d) : rd_beat.re[l];
    assign a_im_d[l] = a_gt ? asr_sat(rd_beat.im[l], d) : rd_beat.im[l];
    assign b_re_d[l] = a_gt ? data_re_in[l] : asr_sat(data_re_in[l], d);
    assign b_im_d[l] = a_gt ? data_im_in[l] : asr_sat(data_im_in[l], d);
  end
`else
  assign a_re_d  = rd_beat.re;
  assign a_im_d  = rd_beat.im;
  assign b_re_d  = data_re_in;
  assign b_im_d  = data_im_in;
  assign exp_a_d = rd_exp;
  assign exp_b_d = exp_in;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_q    <= '0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      a_re_q        <= '0;
      a_im_q        <= '0;
      b_re_q        <= '0;
      b_im_q        <= '0;
      exp_a_q       <= '0;
      exp_b_q       <= '0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      valid_q       <= fire;
      frame_start_q <= fire && first_pair;
      if (fire) begin
        a_re_q  <= a_re_d;
        a_im_q  <= a_im_d;
        b_re_q  <= b_re_d;
        b_im_q  <= b_im_d;
        exp_a_q <= exp_a_d;
        exp_b_q <= exp_b_d;
      end
    end
  end

  assign valid_out   = valid_q;
  assign frame_start = frame_start_q;
  assign a_re        = a_re_q;
  assign a_im        = a_im_q;
  assign b_re        = b_re_q;
  assign b_im        = b_im_q;
  assign exp_a       = exp_a_q;
  assign exp_b       = exp_b_q;

endmodule
